swc_rd_sched: RTL and testbench
===============================

# swc_rd_sched

Deficit-style weighted round-robin scheduler for the switch core read side. It picks which of the four output queue controllers is served next, offers that grant to the shared SRAM read engine over a valid/ready handshake, and waits for the engine's completion pulse before scheduling again. Per-port weights count whole packets: a port keeps the grant until it has sent `weight` packets or becomes ineligible.

## Interface
- `NPORT`, default 4. Number of output queues. Only 4 is supported.
- `TMO_W`, default 6. Width of the busy-watchdog counter. Timeout is 2^TMO_W-1 cycles.
- `clk`, in, 1. Single clock.
- `rstn`, in, 1. Reset, synchronous and active-low.
- `ptr_rdy`, in, 4. Per-queue head pointer valid.
- `o_cell_bp`, in, 4. Per-port output FIFO backpressure.
- `head_last`, in, 4. Per-queue last-cell flag (bit 15) of the head pointer.
- `cfg_weight`, in, 16. Packet weight per port, 4 bits each; port i uses bits [4i+3:4i]. Weight 0 is treated as 1.
- `cfg_wr`, in, 1. One-cycle strobe that latches `cfg_weight` into the weight register.
- `gnt_valid`, out, 1. Grant offered.
- `gnt_port`, out, 4. One-hot granted port. Stable while `gnt_valid` is high.
- `gnt_last`, out, 1. `head_last` of the granted port, registered at offer time.
- `gnt_ready`, in, 1. Read engine accepts the grant and pops the pointer.
- `rd_done`, in, 1. One-cycle pulse: the cell read for the accepted grant has completed.
- `err_tmo`, out, 1. One-cycle pulse when the busy watchdog expires.
- `cell_cnt`, out, 64. Saturating 16-bit accepted-cell counter per port; port i uses bits [16i+15:16i].

## Operation
- A port is eligible when `ptr_rdy[i] & ~o_cell_bp[i]`.
- Registers:
  - `cur`: last served port, 2 bits.
  - `credit`: 4 bits.
  - `weight_q`: 16 bits.
  - watchdog counter: `TMO_W` bits.
- States:
  - **IDLE**. If no port is eligible, stay. Otherwise:
    - If `cur` is eligible and `credit != 0`, select `cur`.
    - Otherwise search the ports in round-robin order starting at `cur+1` (mod 4). Select the first eligible port, set `cur` to it, and load `credit` from `max(weight_q[cur], 1)`.
    - Register `gnt_port` and `gnt_last`, then go to OFFER.
  - **OFFER**. `gnt_valid` = 1.
    - If `gnt_ready`: increment `cell_cnt[cur]` (saturate at 16'hFFFF). If `gnt_last` is set, decrement `credit`. Go to BUSY.
    - Else, if the granted port is no longer eligible: withdraw. `gnt_valid` drops next cycle, `credit` and `cur` are unchanged, go to IDLE.
    - `gnt_ready` takes priority over withdrawal in the same cycle.
  - **BUSY**. `gnt_valid` = 0 and the watchdog increments each cycle.
    - On `rd_done`: clear the watchdog and go to IDLE.
    - If the watchdog reaches its all-ones value without `rd_done`: pulse `err_tmo`, clear the watchdog, force `credit` to 0, and go to IDLE.
- Visit end: when `credit` reaches 0 the next IDLE selection rotates away from `cur`. If `cur` is the only eligible port, it is reselected and its credit reloaded.
- `cfg_wr` updates `weight_q` on the next edge. A new weight affects only subsequent credit loads, never the credit already in flight.
- `gnt_ready` is ignored outside OFFER. `rd_done` is ignored outside BUSY.

## Timing
- Reset values:
  - state = IDLE
  - `gnt_valid` = 0, `gnt_port` = 0, `gnt_last` = 0, `err_tmo` = 0
  - `cur` = 3, so port 0 is searched first
  - `credit` = 0
  - `weight_q` = 16'h1111
  - `cell_cnt` = 0
- Reset asserted mid-OFFER or mid-BUSY returns the block to these values on the next edge. No grant survives reset.
- Latency:
  - An eligible port seen in IDLE at edge N gives `gnt_valid` = 1 after edge N+1.
  - Acceptance at edge M gives `gnt_valid` = 0 after edge M.
  - `rd_done` at edge K puts the block in IDLE after K. The next `gnt_valid` is at K+2 at the earliest.
  - Minimum spacing between accepted grants is 4 cycles when `rd_done` follows acceptance by 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `credit` arithmetic is 4-bit unsigned and never decrements below 0.

## Test plan
- **Single port.** Port 1 always eligible, every cell last, weight 1. Grants are all `4'b0010`, one per handshake, and `cell_cnt[1]` equals the number of accepted grants.
- **Weighted rotation.** All ports eligible, all cells last, weights {port0=2, port1=1, port2=0, port3=3}. The grant sequence from reset repeats 0,0,1,2,3,3,3.
- **Multi-cell packets.** Port 0, weight 1, 3-cell packets (`head_last` = 0,0,1), port 2 also eligible. Grants are 0,0,0,2, with `gnt_last` = 0,0,1.
- **Withdrawal.** Raise `o_cell_bp[0]` while OFFER is holding port 0 and `gnt_ready` is low. `gnt_valid` drops the next cycle. `cell_cnt[0]` is unchanged. Port 0 is granted again after bp clears, with `credit` intact.
- **Watchdog.** Accept a grant and never pulse `rd_done`. `err_tmo` pulses exactly 63 cycles after entry to BUSY (with `TMO_W` = 6), then scheduling resumes and rotates to the next port.
- **Reset and config.**
  - Reset during BUSY: `gnt_valid` = 0 and all counters = 0 next cycle.
  - `cfg_wr` mid-visit: the old credit is honoured and the new weight applies from the next visit.

Source files
------------

// File: rtl/swc_rd_sched_if.sv
// Grant handshake between the read scheduler and the shared SRAM read engine.
interface swc_rd_sched_if;
    logic       gnt_valid;
    logic [3:0] gnt_port;
    logic       gnt_last;
    logic       gnt_ready;
    logic       rd_done;

    modport master (
        output gnt_valid, gnt_port, gnt_last,
        input  gnt_ready, rd_done
    );

    modport slave (
        input  gnt_valid, gnt_port, gnt_last,
        output gnt_ready, rd_done
    );
endinterface

// File: rtl/swc_rd_sched.sv
// Packet-weighted round-robin read scheduler: picks an output queue, offers it to
// the SRAM read engine and waits for the cell read to finish before rescheduling.
module swc_rd_sched #(
    parameter int NPORT = 4,
    parameter int TMO_W = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NPORT-1:0]      ptr_rdy,
    input  logic [NPORT-1:0]      o_cell_bp,
    input  logic [NPORT-1:0]      head_last,
    input  logic [4*NPORT-1:0]    cfg_weight,
    input  logic                  cfg_wr,
    swc_rd_sched_if.master        gnt,
    output logic                  err_tmo,
    output logic [16*NPORT-1:0]   cell_cnt
);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    // Expiry fires on the edge where the count would become all-ones.
    localparam logic [TMO_W-1:0] WDOG_END = TMO_W'((1 << TMO_W) - 2);

    state_t             state;
    logic [1:0]         cur;
    logic [3:0]         credit;
    logic [4*NPORT-1:0] weight_q;
    logic [TMO_W-1:0]   wdog;
    logic [15:0]        cnt_q [NPORT];

    logic [NPORT-1:0]   elig;
    logic               keep;
    logic [1:0]         rr_sel;
    logic [1:0]         idx;
    logic [1:0]         sel;
    logic [3:0]         w_sel;
    logic [3:0]         load;

    assign elig = ptr_rdy & ~o_cell_bp;
    assign keep = elig[cur] && (credit != 4'd0);

    // Descending scan so the lowest offset from cur+1 wins; offset 4 is cur itself.
    always_comb begin
        rr_sel = cur;
        idx    = cur;
        for (int i = NPORT; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (elig[idx]) begin
                rr_sel = idx;
            end
        end
    end

    assign sel   = keep ? cur : rr_sel;
    assign w_sel = weight_q[{rr_sel, 2'b00} +: 4];
    assign load  = (w_sel == 4'd0) ? 4'd1 : w_sel;

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_cnt
            assign cell_cnt[16*g +: 16] = cnt_q[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            gnt.gnt_valid <= 1'b0;
            gnt.gnt_port  <= '0;
            gnt.gnt_last  <= 1'b0;
            err_tmo       <= 1'b0;
            cur           <= 2'd3;
            credit        <= 4'd0;
            weight_q      <= 16'h1111;
            wdog          <= '0;
            for (int i = 0; i < NPORT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_tmo <= 1'b0;
            if (cfg_wr) begin
                weight_q <= cfg_weight;
            end
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        if (!keep) begin
                            cur    <= rr_sel;
                            credit <= load;
                        end
                        gnt.gnt_port <= 4'b0001 << sel;
                        gnt.gnt_last <= head_last[sel];
                        state        <= OFFER;
                    end
                end
                OFFER: begin
                    // gnt_valid rises one cycle after entry, so acceptance needs it high.
                    if (gnt.gnt_valid && gnt.gnt_ready) begin
                        if (cnt_q[cur] != 16'hFFFF) begin
                            cnt_q[cur] <= cnt_q[cur] + 16'd1;
                        end
                        if (gnt.gnt_last && credit != 4'd0) begin
                            credit <= credit - 4'd1;
                        end
                        gnt.gnt_valid <= 1'b0;
                        wdog          <= '0;
                        state         <= BUSY;
                    end else if (!elig[cur]) begin
                        gnt.gnt_valid <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        gnt.gnt_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (gnt.rd_done) begin
                        wdog  <= '0;
                        state <= IDLE;
                    end else if (wdog == WDOG_END) begin
                        err_tmo <= 1'b1;
                        wdog    <= '0;
                        credit  <= 4'd0;
                        state   <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_swc_rd_sched.sv
// Scoreboard bench for swc_rd_sched: expected grants are queued per scenario and
// popped as the bench, acting as the read engine, accepts each offer.
module tb_swc_rd_sched;

    typedef struct {
        int port;
        bit last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  ptr_rdy;
    logic [3:0]  o_cell_bp;
    logic [3:0]  head_last;
    logic [15:0] cfg_weight;
    logic        cfg_wr;
    logic        err_tmo;
    logic [63:0] cell_cnt;

    swc_rd_sched_if gnt_bus ();

    swc_rd_sched #(.NPORT(4), .TMO_W(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ptr_rdy    (ptr_rdy),
        .o_cell_bp  (o_cell_bp),
        .head_last  (head_last),
        .cfg_weight (cfg_weight),
        .cfg_wr     (cfg_wr),
        .gnt        (gnt_bus),
        .err_tmo    (err_tmo),
        .cell_cnt   (cell_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cnt_model [4];
    int   pkt_len [4];
    int   cell_idx [4];
    int   accept_cyc;
    exp_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic refreshHead();
        for (int i = 0; i < 4; i++) begin
            head_last[i] = (cell_idx[i] == pkt_len[i] - 1);
        end
    endtask

    task automatic pushExp(input int port, input bit last);
        exp_t e;
        e.port = port;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            cnt_model[i] = 0;
            pkt_len[i]   = 1;
            cell_idx[i]  = 0;
        end
        exp_q.delete();
        refreshHead();
    endtask

    task automatic doReset();
        rstn              = 1'b0;
        ptr_rdy           = 4'b0;
        o_cell_bp         = 4'b0;
        cfg_wr            = 1'b0;
        cfg_weight        = 16'h0;
        gnt_bus.gnt_ready = 1'b0;
        gnt_bus.rd_done   = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic setWeights(input logic [15:0] w);
        cfg_weight = w;
        cfg_wr     = 1'b1;
        @(negedge clk);
        cfg_wr     = 1'b0;
    endtask

    task automatic waitGrant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (gnt_bus.gnt_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("grant_wait", 64'(ok), 64'd1);
    endtask

    // Acts as the read engine for one grant: checks it against the scoreboard,
    // accepts it and optionally completes the read one cycle later.
    task automatic applyStimulus(input bit send_done);
        bit   ok;
        exp_t e;
        waitGrant(ok);
        if (!ok) return;
        checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checkOutput("gnt_port", 64'(gnt_bus.gnt_port), 64'd1 << e.port);
        checkOutput("gnt_last", 64'(gnt_bus.gnt_last), 64'(e.last));
        gnt_bus.gnt_ready = 1'b1;
        @(negedge clk);
        gnt_bus.gnt_ready = 1'b0;
        accept_cyc = cyc;
        checkOutput("valid_drop", 64'(gnt_bus.gnt_valid), 64'd0);
        if (cnt_model[e.port] < 16'hFFFF) cnt_model[e.port]++;
        cell_idx[e.port] = (cell_idx[e.port] + 1) % pkt_len[e.port];
        refreshHead();
        if (send_done) begin
            gnt_bus.rd_done = 1'b1;
            @(negedge clk);
            gnt_bus.rd_done = 1'b0;
        end
    endtask

    task automatic checkCounts();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("cell_cnt%0d", i), 64'(cell_cnt[16*i +: 16]), 64'(cnt_model[i]));
        end
    endtask

    initial begin
        int prev;
        int seq [7];
        bit seen;
        seq = '{0, 0, 1, 2, 3, 3, 3};
        @(negedge clk);

        // Reset values
        doReset();
        checkOutput("rst_valid", 64'(gnt_bus.gnt_valid), 64'd0);
        checkOutput("rst_port", 64'(gnt_bus.gnt_port), 64'd0);
        checkOutput("rst_last", 64'(gnt_bus.gnt_last), 64'd0);
        checkOutput("rst_err", 64'(err_tmo), 64'd0);
        checkOutput("rst_cnt", cell_cnt, 64'd0);

        // Single port, back-to-back with minimum spacing
        ptr_rdy = 4'b0010;
        prev = 0;
        for (int k = 0; k < 5; k++) pushExp(1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1);
            if (k > 0) checkOutput("spacing", 64'(accept_cyc - prev), 64'd4);
            prev = accept_cyc;
        end
        checkCounts();

        // Weighted rotation, weight 0 behaves as 1
        doReset();
        setWeights(16'h3012);
        ptr_rdy = 4'hF;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 7; k++) pushExp(seq[k], 1'b1);
        for (int k = 0; k < 14; k++) applyStimulus(1'b1);
        checkCounts();

        // Multi-cell packets: credit only drops on the last cell
        doReset();
        pkt_len[0] = 3;
        refreshHead();
        ptr_rdy = 4'b0101;
        pushExp(0, 1'b0);
        pushExp(0, 1'b0);
        pushExp(0, 1'b1);
        pushExp(2, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1);
        checkCounts();

        // Withdrawal keeps cur and the remaining credit
        doReset();
        setWeights(16'h1112);
        ptr_rdy = 4'b0001;
        pushExp(0, 1'b1);
        applyStimulus(1'b1);
        waitGrant(seen);
        checkOutput("wd_port", 64'(gnt_bus.gnt_port), 64'd1);
        o_cell_bp = 4'b0001;
        @(negedge clk);
        checkOutput("wd_valid", 64'(gnt_bus.gnt_valid), 64'd0);
        checkOutput("wd_cnt0", 64'(cell_cnt[15:0]), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("wd_idle", 64'(gnt_bus.gnt_valid), 64'd0);
        o_cell_bp = 4'b0000;
        ptr_rdy   = 4'b0011;
        pushExp(0, 1'b1);
        pushExp(1, 1'b1);
        for (int k = 0; k < 2; k++) applyStimulus(1'b1);
        checkCounts();

        // Watchdog: no rd_done after acceptance
        doReset();
        setWeights(16'h1112);
        ptr_rdy = 4'b0011;
        pushExp(0, 1'b1);
        applyStimulus(1'b0);
        prev = accept_cyc;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err_tmo) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("tmo_seen", 64'(seen), 64'd1);
        checkOutput("tmo_delay", 64'(cyc - prev), 64'd63);
        @(negedge clk);
        checkOutput("tmo_pulse", 64'(err_tmo), 64'd0);
        pushExp(1, 1'b1);
        applyStimulus(1'b1);
        checkCounts();

        // Reset while BUSY
        doReset();
        ptr_rdy = 4'b0001;
        pushExp(0, 1'b1);
        applyStimulus(1'b0);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("rb_valid", 64'(gnt_bus.gnt_valid), 64'd0);
        checkOutput("rb_port", 64'(gnt_bus.gnt_port), 64'd0);
        checkOutput("rb_cnt", cell_cnt, 64'd0);
        rstn = 1'b1;
        clearModel();
        ptr_rdy = 4'b0011;
        pushExp(0, 1'b1);
        applyStimulus(1'b1);
        checkCounts();

        // Weight change mid-visit only affects the next credit load
        doReset();
        setWeights(16'h1113);
        ptr_rdy = 4'b0011;
        pushExp(0, 1'b1);
        pushExp(0, 1'b1);
        pushExp(0, 1'b1);
        pushExp(1, 1'b1);
        pushExp(0, 1'b1);
        pushExp(1, 1'b1);
        applyStimulus(1'b0);
        setWeights(16'h1111);
        gnt_bus.rd_done = 1'b1;
        @(negedge clk);
        gnt_bus.rd_done = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1);
        checkCounts();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
